// File: rtl/comb_equiv_checker.sv
// comb_equiv_checker: sweeps the full N_IN-bit input space into N_CH copies of
// one combinational function and compares every channel against channel 0.
// Reports busy/done/pass, the number of mismatching vectors, and the vector and
// channel mask of the first mismatch.
module comb_equiv_checker #(
  parameter int N_IN   = 4,  // input vector width, 2..8
  parameter int N_CH   = 4,  // channels compared, 2..16; channel 0 is golden
  parameter int SETTLE = 1   // settle cycles per vector, 0..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  output logic [N_IN-1:0]   stim,
  input  logic [N_CH-1:0]   dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [N_CH-1:0]   first_fail_mask
);

  // Feedback taps for a maximal-length shift-left Fibonacci LFSR.
  // Bit k of the mask selects state bit k into the XOR feedback.
  function automatic logic [7:0] tap_mask(input int n);
    case (n)
      2:       tap_mask = 8'b0000_0011;  // x^2 + x + 1
      3:       tap_mask = 8'b0000_0110;  // x^3 + x^2 + 1
      4:       tap_mask = 8'b0000_1100;  // x^4 + x^3 + 1
      5:       tap_mask = 8'b0001_0100;  // x^5 + x^3 + 1
      6:       tap_mask = 8'b0011_0000;  // x^6 + x^5 + 1
      7:       tap_mask = 8'b0110_0000;  // x^7 + x^6 + 1
      8:       tap_mask = 8'b1011_1000;  // x^8 + x^6 + x^5 + x^4 + 1
      default: tap_mask = 8'b0000_0000;
    endcase
  endfunction

  localparam logic [7:0]      TAP_MASK8 = tap_mask(N_IN);
  localparam logic [N_IN-1:0] TAP_MASK  = TAP_MASK8[N_IN-1:0];
  localparam logic [3:0]      SETTLE_W  = 4'(SETTLE);
  localparam logic [N_IN-1:0] VEC_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE   = {{N_IN{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [3:0]        wait_q, wait_d;
  logic [N_IN-1:0]   vec_q, vec_d;      // index of the vector under test
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic [N_CH-1:0]   ffm_q, ffm_d;

  logic [N_CH-1:0]   diff_mask;
  logic              mismatch;
  logic              lfsr_fb;
  logic [N_IN-1:0]   next_vec;

  // Per-channel disagreement with the golden channel, and the next vector in sweep order.
  always_comb begin
    diff_mask = dut_out ^ {N_CH{dut_out[0]}};
    mismatch  = |diff_mask;
    lfsr_fb   = ^(stim_q & TAP_MASK);
    next_vec  = stim_q + VEC_ONE;
    if (mode_q) begin
      // LFSR order visits 0 first, then seeds with 1 since the LFSR never reaches 0.
      if (vec_q == '0) begin
        next_vec = VEC_ONE;
      end else begin
        next_vec = {stim_q[N_IN-2:0], lfsr_fb};
      end
    end
  end

  // Next-state logic for the sweep controller and its result registers.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wait_d  = wait_q;
    vec_d   = vec_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          mode_d  = mode;
          wait_d  = SETTLE_W;
          vec_d   = '0;
          stim_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          ffv_d   = '0;
          ffm_d   = '0;
        end
      end

      S_SETTLE: begin
        if (wait_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          cnt_d = cnt_q + CNT_ONE;
          // Only the first mismatch of the sweep is recorded.
          if (cnt_q == '0) begin
            ffv_d = stim_q;
            ffm_d = diff_mask;
          end
        end
        // The vector count, not the stim value, ends the sweep (LFSR order is not monotonic).
        if (vec_q == '1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETTLE;
          stim_d  = next_vec;
          vec_d   = vec_q + VEC_ONE;
          wait_d  = SETTLE_W;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset wins over everything and aborts a running sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      wait_q  <= 4'd0;
      vec_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
      vec_q   <= vec_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q & (cnt_q == '0);
  assign mismatch_cnt    = cnt_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_comb_equiv_checker.sv
// Testbench for comb_equiv_checker: directed sweeps against bench-modelled channels,
// with an expected-vector queue compared at each vector boundary.
module tb_comb_equiv_checker;

  localparam int PER = 3;   // SETTLE + 2 for the main instance
  localparam int NV  = 16;  // 2^N_IN for the main instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: N_IN=4, N_CH=4, SETTLE=1
  logic       rst_n, start, mode;
  logic [3:0] stim, dut_out, ffv, ffm;
  logic       busy, done, pass;
  logic [4:0] mismatch_cnt;
  int         scen;

  // Small instance: N_IN=2, N_CH=2, SETTLE=0
  logic       start_b, mode_b;
  logic [1:0] stim_b, dut_out_b, ffv_b, ffm_b;
  logic       busy_b, done_b, pass_b;
  logic [2:0] mismatch_cnt_b;

  comb_equiv_checker #(.N_IN(4), .N_CH(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .stim(stim),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_vec(ffv), .first_fail_mask(ffm)
  );

  comb_equiv_checker #(.N_IN(2), .N_CH(2), .SETTLE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .stim(stim_b),
    .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_cnt(mismatch_cnt_b), .first_fail_vec(ffv_b), .first_fail_mask(ffm_b)
  );

  // Channel models: {ch3, ch2, ch1, ch0}
  always_comb begin
    dut_out = {4{^stim}};
    case (scen)
      2: if (stim == 4'h5) dut_out[2] = ~dut_out[2];
      3: dut_out = {1'b1, &stim, 1'b1, &stim};
      default: dut_out = {4{^stim}};
    endcase
  end

  always_comb dut_out_b = {2{^stim_b}};

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One full sweep of the main instance; restart_at >= 0 pulses start mid-sweep.
  task automatic sweep(input string tag, input int sc, input logic m, input int restart_at,
                       input int e_cnt, input logic [3:0] e_ffv, input logic [3:0] e_ffm,
                       input logic e_pass);
    logic [15:0] seen;
    int          cyc;
    int          in_order;
    logic [3:0]  v;
    logic [3:0]  e;
    scen = sc;
    seen = '0;
    in_order = 0;
    exp_q.delete();
    if (!m) begin
      for (int i = 0; i < NV; i++) exp_q.push_back(i[3:0]);
    end else begin
      exp_q.push_back(4'h0);
      exp_q.push_back(4'h1);
    end
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_cnt_clr"}, mismatch_cnt, 0);
    chk({tag, "_ffv_clr"}, ffv, 0);
    chk({tag, "_ffm_clr"}, ffm, 0);
    for (int k = 0; k < NV; k++) begin
      if (k > 0) begin
        for (int j = 0; j < PER; j++) begin
          start = (cyc == restart_at);
          tick();
          start = 1'b0;
          cyc++;
        end
      end
      v = stim;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("%s vec %0d stim=%0h exp=%0h", tag, k, v, e);
        chk({tag, "_stim"}, v, e);
      end else begin
        $display("%s vec %0d stim=%0h", tag, k, v);
      end
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_pass_busy"}, pass, 0);
      seen[v] = 1'b1;
      if (v == k[3:0]) in_order++;
    end
    chk({tag, "_distinct"}, $countones(seen), NV);
    if (m) chk({tag, "_lfsr_not_binary"}, (in_order < NV), 1);
    tick();
    tick();
    chk({tag, "_done_early"}, done, 0);
    tick();
    chk({tag, "_done_at_48"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_pass"}, pass, e_pass);
    chk({tag, "_cnt"}, mismatch_cnt, e_cnt);
    chk({tag, "_ffv"}, ffv, e_ffv);
    chk({tag, "_ffm"}, ffm, e_ffm);
    if (!m) chk({tag, "_stim_last"}, stim, 4'hF);
    repeat (3) tick();
    chk({tag, "_done_held"}, done, 1);
    if (!m) chk({tag, "_stim_held"}, stim, 4'hF);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; start_b = 1'b0; mode_b = 1'b0; scen = 1;
    tick();
    tick();
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_ffv", ffv, 0);
    chk("rst_ffm", ffm, 0);
    rst_n = 1'b1;
    tick();

    // 1: identical XOR channels, binary order
    sweep("t1", 1, 1'b0, -1, 0, 4'h0, 4'h0, 1'b1);
    // 2: channel 2 inverted at stim 5
    sweep("t2", 2, 1'b0, -1, 1, 4'h5, 4'b0100, 1'b0);
    // 4: restart from DONE clears counters; start pulse 10 cycles in is ignored
    sweep("t4", 1, 1'b0, 9, 0, 4'h0, 4'h0, 1'b1);
    // 3: channels 1 and 3 stuck at 1 against AND, LFSR order
    sweep("t3", 3, 1'b1, -1, 15, 4'h0, 4'b1010, 1'b0);

    // 5: reset mid-sweep at stim 7
    scen = 2;
    mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7 * PER) tick();
    chk("t5_stim7", stim, 4'h7);
    chk("t5_cnt_pre", mismatch_cnt, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_stim", stim, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_pass", pass, 0);
    chk("t5_cnt", mismatch_cnt, 0);
    chk("t5_ffv", ffv, 0);
    chk("t5_ffm", ffm, 0);
    repeat (5) tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_done", done, 0);
    chk("t5_idle_stim", stim, 0);

    // 6: small instance, SETTLE=0
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t6_busy", busy_b, 1);
    repeat (7) tick();
    chk("t6_done_early", done_b, 0);
    tick();
    $display("t6 done=%0d pass=%0d cnt=%0d", done_b, pass_b, mismatch_cnt_b);
    chk("t6_done", done_b, 1);
    chk("t6_pass", pass_b, 1);
    chk("t6_cnt", mismatch_cnt_b, 0);
    chk("t6_ffm", ffm_b, 0);
    chk("t6_stim_last", stim_b, 2'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
